// File: rtl/pulse_param_loader_pkg.sv
// Shared constants for the pulse parameter loader: sync byte, register IDs,
// per-ID payload lengths, FSM state encoding and power-on defaults.
package pulse_param_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] ID_PER    = 8'h00;
  localparam logic [7:0] ID_NUT_W  = 8'h09;
  localparam logic [7:0] ID_PR_ATT = 8'h0A;
  localparam logic [7:0] ID_FLAGS  = 8'h0B;
  localparam logic [7:0] ID_APPLY  = 8'hFF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ID   = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_CSUM = 2'd3;

  localparam logic [31:0] DEF_PER    = 32'd10000;
  localparam logic [7:0]  DEF_NUT_W  = 8'd0;
  localparam logic [6:0]  DEF_PR_ATT = 7'd0;
  localparam logic        DEF_CP     = 1'b1;
  localparam logic        DEF_BL     = 1'b0;

  function automatic logic id_known(input logic [7:0] id);
    return (id <= ID_FLAGS) || (id == ID_APPLY);
  endfunction

  function automatic logic [2:0] id_nbytes(input logic [7:0] id);
    case (id)
      ID_PER:                       return 3'd4;
      ID_NUT_W, ID_PR_ATT, ID_FLAGS: return 3'd1;
      ID_APPLY:                     return 3'd0;
      default:                      return 3'd2;
    endcase
  endfunction

  // 16-bit bank index 0..7 maps to IDs 0x01..0x08 (p1wid .. nut_d).
  function automatic logic [15:0] def16(input int unsigned idx);
    case (idx)
      0:       return 16'd20;
      1:       return 16'd200;
      2:       return 16'd40;
      default: return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/pulse_param_loader_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop check.
// Emits a one-cycle rx_valid (good stop) or rx_ferr (stop low) per byte.
module uart_rx_byte #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]    sync_q;
  logic          prev_q;
  logic [1:0]    st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          valid_q;
  logic          ferr_q;
  logic          rxs;
  logic          bit_end;

  assign rxs     = sync_q[1];
  assign bit_end = (cnt_q == CW'(BIT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      prev_q  <= rxs;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (st_q)
        RX_IDLE: begin
          if (prev_q && !rxs) begin
            st_q  <= RX_START;
            cnt_q <= '0;
          end
        end
        RX_START: begin
          // Re-check the start bit at its centre to reject glitches.
          if (cnt_q == CW'(HALF_CYC - 1)) begin
            cnt_q <= '0;
            bit_q <= '0;
            st_q  <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) st_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          if (bit_end) begin
            valid_q <= rxs;
            ferr_q  <= !rxs;
            cnt_q   <= '0;
            st_q    <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Shift register holds the byte stable until the next byte's data bits.
  always_ff @(posedge clk) begin
    if (st_q == RX_DATA && bit_end) sh_q <= {rxs, sh_q[7:1]};
  end

  assign rx_data  = sh_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/pulse_param_loader.sv
// Serial pulse-parameter loader: UART packets fill shadow registers, apply
// copies all shadows to the live outputs at once. Define PARAM_CHECKSUM_EN to
// require a trailing XOR checksum byte on every packet.
module pulse_param_loader #(
  parameter int CLK_FREQ    = 12_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 120000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [15:0] p1wid2,
  output logic [15:0] del2,
  output logic [15:0] p2wid2,
  output logic [15:0] p1st2,
  output logic [15:0] nut_d,
  output logic [7:0]  nut_w,
  output logic [6:0]  pr_att,
  output logic        cp,
  output logic        bl,
  output logic        pkt_ok,
  output logic        pkt_err
);
  import pulse_param_loader_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ferr;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    id_q, id_d;
  logic [31:0]   asm_q, asm_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          done, err;
  logic [7:0]    commit_id;
  logic [31:0]   commit_val;
  logic          pkt_ok_q, pkt_err_q;

  logic [31:0] sh_per_q, lv_per_q;
  logic [15:0] sh16_q [8];
  logic [15:0] lv16_q [8];
  logic [7:0]  sh_nut_w_q, lv_nut_w_q;
  logic [6:0]  sh_pr_att_q, lv_pr_att_q;
  logic        sh_cp_q, lv_cp_q, sh_bl_q, lv_bl_q;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk(clk), .reset(reset), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    done       = 1'b0;
    err        = 1'b0;
    commit_id  = id_q;
    commit_val = asm_q;
    case (state_q)
      ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_ID;
      ST_ID: if (rx_valid) begin
        if (!id_known(rx_data)) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          id_d   = rx_data;
          cnt_d  = id_nbytes(rx_data);
          csum_d = rx_data;
          asm_d  = '0;
          if (id_nbytes(rx_data) != 3'd0) begin
            state_d = ST_DATA;
          end else begin
`ifdef PARAM_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            done      = 1'b1;
            commit_id = rx_data;
            state_d   = ST_IDLE;
`endif
          end
        end
      end
      ST_DATA: if (rx_valid) begin
        asm_d  = {asm_q[23:0], rx_data};
        csum_d = csum_q ^ rx_data;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
`ifdef PARAM_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          done       = 1'b1;
          commit_val = asm_d;
          state_d    = ST_IDLE;
`endif
        end
      end
      default: if (rx_valid) begin
        if (rx_data == csum_q) done = 1'b1;
        else                   err  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    // Framing errors and gaps abort a packet; a byte in the same cycle wins.
    if (state_q != ST_IDLE) begin
      if (rx_ferr) begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end else if (!rx_valid && timer_q == TW'(TIMEOUT_CYC - 1)) begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
    end
    if (state_d == ST_IDLE || rx_valid || rx_ferr) timer_d = '0;
    else                                           timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      id_q        <= '0;
      asm_q       <= '0;
      csum_q      <= '0;
      timer_q     <= '0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      sh_per_q    <= DEF_PER;     lv_per_q    <= DEF_PER;
      sh_nut_w_q  <= DEF_NUT_W;   lv_nut_w_q  <= DEF_NUT_W;
      sh_pr_att_q <= DEF_PR_ATT;  lv_pr_att_q <= DEF_PR_ATT;
      sh_cp_q     <= DEF_CP;      lv_cp_q     <= DEF_CP;
      sh_bl_q     <= DEF_BL;      lv_bl_q     <= DEF_BL;
      for (int i = 0; i < 8; i++) begin
        sh16_q[i] <= def16(i);
        lv16_q[i] <= def16(i);
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      asm_q     <= asm_d;
      csum_q    <= csum_d;
      timer_q   <= timer_d;
      pkt_ok_q  <= done;
      pkt_err_q <= err;
      if (done) begin
        case (commit_id)
          ID_PER:    sh_per_q    <= commit_val;
          ID_NUT_W:  sh_nut_w_q  <= commit_val[7:0];
          ID_PR_ATT: sh_pr_att_q <= commit_val[6:0];
          ID_FLAGS: begin
            sh_cp_q <= commit_val[0];
            sh_bl_q <= commit_val[1];
          end
          ID_APPLY: begin
            lv_per_q    <= sh_per_q;
            lv16_q      <= sh16_q;
            lv_nut_w_q  <= sh_nut_w_q;
            lv_pr_att_q <= sh_pr_att_q;
            lv_cp_q     <= sh_cp_q;
            lv_bl_q     <= sh_bl_q;
          end
          default: sh16_q[commit_id[2:0] - 3'd1] <= commit_val[15:0];
        endcase
      end
    end
  end

  assign per     = lv_per_q;
  assign p1wid   = lv16_q[0];
  assign del     = lv16_q[1];
  assign p2wid   = lv16_q[2];
  assign p1wid2  = lv16_q[3];
  assign del2    = lv16_q[4];
  assign p2wid2  = lv16_q[5];
  assign p1st2   = lv16_q[6];
  assign nut_d   = lv16_q[7];
  assign nut_w   = lv_nut_w_q;
  assign pr_att  = lv_pr_att_q;
  assign cp      = lv_cp_q;
  assign bl      = lv_bl_q;
  assign pkt_ok  = pkt_ok_q;
  assign pkt_err = pkt_err_q;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Self-checking bench for pulse_param_loader: table vectors, corner sequences
// and random packets against a register-map level reference model.
module tb_pulse_param_loader;

  localparam int BIT = 10;
  localparam int TO  = 400;
`ifdef PARAM_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_d;
  logic [7:0]  nut_w;
  logic [6:0]  pr_att;
  logic        cp, bl, pkt_ok, pkt_err;

  always #5 clk = ~clk;

  pulse_param_loader #(.CLK_FREQ(1_000_000), .BAUD(100_000), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .p1wid2(p1wid2),
    .del2(del2), .p2wid2(p2wid2), .p1st2(p1st2), .nut_d(nut_d), .nut_w(nut_w),
    .pr_att(pr_att), .cp(cp), .bl(bl), .pkt_ok(pkt_ok), .pkt_err(pkt_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ok_cnt  = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (pkt_ok)  ok_cnt++;
    if (pkt_err) err_cnt++;
  end

  // Reference model: staged and live value per register-map ID 0x00..0x0B.
  logic [31:0] m_sh [12];
  logic [31:0] m_lv [12];

  function automatic int id_len(input logic [7:0] id);
    if (id == 8'h00) return 4;
    if (id >= 8'h01 && id <= 8'h08) return 2;
    if (id >= 8'h09 && id <= 8'h0B) return 1;
    if (id == 8'hFF) return 0;
    return -1;
  endfunction

  function automatic logic [31:0] id_mask(input logic [7:0] id);
    if (id == 8'h00) return 32'hFFFF_FFFF;
    if (id <= 8'h08) return 32'h0000_FFFF;
    if (id == 8'h09) return 32'h0000_00FF;
    if (id == 8'h0A) return 32'h0000_007F;
    return 32'h0000_0003;
  endfunction

  function automatic logic [31:0] get_live(input logic [7:0] id);
    case (id)
      8'h00: return per;
      8'h01: return {16'd0, p1wid};
      8'h02: return {16'd0, del};
      8'h03: return {16'd0, p2wid};
      8'h04: return {16'd0, p1wid2};
      8'h05: return {16'd0, del2};
      8'h06: return {16'd0, p2wid2};
      8'h07: return {16'd0, p1st2};
      8'h08: return {16'd0, nut_d};
      8'h09: return {24'd0, nut_w};
      8'h0A: return {25'd0, pr_att};
      default: return {30'd0, bl, cp};
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 12; i++) m_sh[i] = 32'd0;
    m_sh[0]  = 32'd10000;
    m_sh[1]  = 32'd20;
    m_sh[2]  = 32'd200;
    m_sh[3]  = 32'd40;
    m_sh[11] = 32'd1;
    m_lv = m_sh;
  endtask

  task automatic check_live(input string tag);
    for (int i = 0; i < 12; i++)
      cmp($sformatf("%s.live[%0d]", tag, i), get_live(8'(i)), m_lv[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = !bad_stop;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    if (bad_stop) repeat (BIT) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] id, input logic [31:0] val, input bit bad,
                          input string tag, output int okd, output int errd);
    int n, ok0, err0;
    logic [7:0] cs, b;
    bit exp_err;
    n = id_len(id);
    ok0 = ok_cnt;
    err0 = err_cnt;
    send_byte(8'hA5, 1'b0);
    send_byte(id, 1'b0);
    cs = id;
    if (n >= 0) begin
      for (int k = n - 1; k >= 0; k--) begin
        b = val[8*k +: 8];
        send_byte(b, 1'b0);
        cs ^= b;
      end
      if (CSUM_EN) send_byte(bad ? (cs ^ 8'h5A) : cs, 1'b0);
    end
    repeat (4) @(negedge clk);
    okd = ok_cnt - ok0;
    errd = err_cnt - err0;
    exp_err = (n < 0) || (bad && CSUM_EN);
    if (!exp_err) begin
      if (id == 8'hFF) m_lv = m_sh;
      else m_sh[id[3:0]] = val & id_mask(id);
    end
    cmp({tag, ".ok"}, okd, exp_err ? 0 : 1);
    cmp({tag, ".err"}, errd, exp_err ? 1 : 0);
    check_live(tag);
  endtask

  task automatic apply(input string tag);
    int okd, errd;
    send_pkt(8'hFF, 32'd0, 1'b0, tag, okd, errd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0]  id;
    logic [31:0] val;
    int          exp_ok;
    int          exp_err;
    logic [7:0]  chk_id;
    logic [31:0] exp_live;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int okd, errd, ok0, err0;
    logic [7:0] id, nz;
    int r;

    vecs[0]  = '{8'h00, 32'd20000,     1, 0, 8'h00, 32'd20000};
    vecs[1]  = '{8'h01, 32'd100,       1, 0, 8'h01, 32'd100};
    vecs[2]  = '{8'h02, 32'h0000_ABCD, 1, 0, 8'h02, 32'hABCD};
    vecs[3]  = '{8'h03, 32'h0000_0001, 1, 0, 8'h03, 32'h1};
    vecs[4]  = '{8'h04, 32'h0000_FFFF, 1, 0, 8'h04, 32'hFFFF};
    vecs[5]  = '{8'h05, 32'h0000_5A5A, 1, 0, 8'h05, 32'h5A5A};
    vecs[6]  = '{8'h06, 32'h0000_00A5, 1, 0, 8'h06, 32'hA5};
    vecs[7]  = '{8'h07, 32'h0000_1234, 1, 0, 8'h07, 32'h1234};
    vecs[8]  = '{8'h08, 32'h0000_BEEF, 1, 0, 8'h08, 32'hBEEF};
    vecs[9]  = '{8'h09, 32'h0000_00C3, 1, 0, 8'h09, 32'hC3};
    vecs[10] = '{8'h0A, 32'h0000_00FF, 1, 0, 8'h0A, 32'h7F};
    vecs[11] = '{8'h0B, 32'h0000_0002, 1, 0, 8'h0B, 32'h2};
    vecs[12] = '{8'h0B, 32'h0000_00FD, 1, 0, 8'h0B, 32'h1};
    vecs[13] = '{8'h20, 32'h0000_0000, 0, 1, 8'h00, 32'd20000};
    vecs[14] = '{8'h00, 32'hDEAD_BEEF, 1, 0, 8'h00, 32'hDEADBEEF};

    // Reset defaults
    do_reset();
    cmp("rst.pkt_ok", {31'd0, pkt_ok}, 32'd0);
    cmp("rst.pkt_err", {31'd0, pkt_err}, 32'd0);
    cmp("rst.per", per, 32'd10000);
    cmp("rst.cp", {31'd0, cp}, 32'd1);
    check_live("rst");

    // Write then apply: live value holds until the apply
    send_pkt(8'h00, 32'd20000, 1'b0, "wr", okd, errd);
    cmp("wr.per_held", per, 32'd10000);
    apply("wr.apply");
    cmp("wr.per_applied", per, 32'd20000);

    // Table vectors, each followed by an apply
    for (int i = 0; i < 15; i++) begin
      send_pkt(vecs[i].id, vecs[i].val, 1'b0, $sformatf("vec%0d", i), okd, errd);
      cmp($sformatf("vec%0d.tab_ok", i), okd, vecs[i].exp_ok);
      cmp($sformatf("vec%0d.tab_err", i), errd, vecs[i].exp_err);
      apply($sformatf("vec%0d.apply", i));
      cmp($sformatf("vec%0d.tab_live", i), get_live(vecs[i].chk_id), vecs[i].exp_live);
    end

`ifdef PARAM_CHECKSUM_EN
    // Bad checksum writes nothing; the corrected packet lands
    send_pkt(8'h01, 32'd77, 1'b1, "badcs", okd, errd);
    apply("badcs.apply");
    cmp("badcs.p1wid", {16'd0, p1wid}, 32'd100);
    send_pkt(8'h01, 32'd100 + 32'd5, 1'b0, "goodcs", okd, errd);
    apply("goodcs.apply");
    cmp("goodcs.p1wid", {16'd0, p1wid}, 32'd105);
`endif

    // Inter-byte timeout mid-packet
    ok0 = ok_cnt;
    err0 = err_cnt;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (TO + 10) @(negedge clk);
    cmp("timeout.err", err_cnt - err0, 1);
    cmp("timeout.ok", ok_cnt - ok0, 0);
    send_pkt(8'h02, 32'h0777, 1'b0, "after_to", okd, errd);
    apply("after_to.apply");

    // Noise byte in IDLE is silently dropped; unknown ID errors
    err0 = err_cnt;
    send_byte(8'h33, 1'b0);
    repeat (4) @(negedge clk);
    cmp("noise.err", err_cnt - err0, 0);
    send_pkt(8'h07, 32'h0BAD, 1'b0, "after_noise", okd, errd);
    send_pkt(8'h20, 32'd0, 1'b0, "unknown", okd, errd);
    send_pkt(8'h0B, 32'h02, 1'b0, "flags", okd, errd);
    apply("flags.apply");
    cmp("flags.cp", {31'd0, cp}, 32'd0);
    cmp("flags.bl", {31'd0, bl}, 32'd1);

    // Framing error inside a packet errors; in IDLE it is ignored
    err0 = err_cnt;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b1);
    repeat (4) @(negedge clk);
    cmp("ferr_pkt.err", err_cnt - err0, 1);
    err0 = err_cnt;
    send_byte(8'h44, 1'b1);
    repeat (4) @(negedge clk);
    cmp("ferr_idle.err", err_cnt - err0, 0);
    send_pkt(8'h04, 32'h0321, 1'b0, "after_ferr", okd, errd);
    apply("after_ferr.apply");

    // Reset in the middle of a packet
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    do_reset();
    @(negedge clk);
    cmp("midrst.pkt_ok", {31'd0, pkt_ok}, 32'd0);
    cmp("midrst.pkt_err", {31'd0, pkt_err}, 32'd0);
    check_live("midrst");
    send_pkt(8'h03, 32'h0042, 1'b0, "after_rst", okd, errd);
    apply("after_rst.apply");

    // Random packets against the model
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        nz = 8'($urandom_range(0, 255));
        if (nz == 8'hA5) nz = 8'h5A;
        send_byte(nz, 1'b0);
      end
      r = $urandom_range(0, 9);
      if (r < 6)       id = 8'($urandom_range(0, 11));
      else if (r < 8)  id = 8'hFF;
      else if (r == 8) id = 8'($urandom_range(12, 254));
      else             id = 8'($urandom_range(0, 11));
      send_pkt(id, $urandom, (r == 9), $sformatf("rnd%0d", t), okd, errd);
    end
    apply("rnd.final_apply");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
